// File: rtl/keyboard_pkg.sv
// rtl/keyboard_pkg.sv - scancode constants, FSM states and ROM address layout for keymap_sequencer
package keyboard_pkg;

    localparam int KEYCODE_W  = 8;
    localparam int ROM_ADDR_W = KEYCODE_W + 2;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;
    localparam logic [7:0] SC_CTRL   = 8'h14;

    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR_LO = 8'h00;
    localparam logic [7:0] SC_ERR_HI = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK,
        ST_LOOKUP,
        ST_CAPTURE
    } state_e;

    // Keyboard housekeeping bytes that carry no key information.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == SC_PAUSE) || (code == SC_BAT) || (code == SC_ACK) ||
               (code == SC_RESEND) || (code == SC_ERR_LO) || (code == SC_ERR_HI);
    endfunction

endpackage

// File: rtl/char_fifo.sv
// rtl/char_fifo.sv - synchronous FIFO, pop applied before push so a full FIFO accepts a push while popping
module char_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_en;
    logic             pop_en;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = empty ? '0 : mem_q[rptr_q];

    always_comb begin
        pop_en  = pop & ~empty;
        push_en = push & (~full | pop_en);
        wptr_d  = push_en ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop_en  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/keymap_sequencer.sv
// rtl/keymap_sequencer.sv - PS/2 scancode to ASCII via keymap ROM; optional left-ctrl handling under CTRL_KEY_EN
module keymap_sequencer
    import keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [KEYCODE_W-1:0]  scancode,
    input  logic                  scancode_valid,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [7:0]            rom_dout,
    output logic [7:0]            char_out,
    output logic                  char_valid,
    input  logic                  char_ready,
    output logic                  caps_lock,
    output logic                  overrun,
    output logic                  overflow
);

    state_e                state_q, state_d;
    logic                  lshift_q, lshift_d;
    logic                  rshift_q, rshift_d;
    logic                  caps_q, caps_d;
    logic                  caps_held_q, caps_held_d;
    logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic                  overrun_q, overrun_d;
    logic                  overflow_q, overflow_d;
`ifdef CTRL_KEY_EN
    logic                  ctrl_held_q, ctrl_held_d;
`endif

    logic       fifo_push;
    logic [7:0] fifo_push_data;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;

    assign char_valid = ~fifo_empty;
    assign fifo_pop   = char_valid & char_ready;

    always_comb begin
        state_d        = state_q;
        lshift_d       = lshift_q;
        rshift_d       = rshift_q;
        caps_d         = caps_q;
        caps_held_d    = caps_held_q;
        rom_addr_d     = rom_addr_q;
        overrun_d      = overrun_q;
        overflow_d     = overflow_q;
`ifdef CTRL_KEY_EN
        ctrl_held_d    = ctrl_held_q;
`endif
        fifo_push      = 1'b0;
        fifo_push_data = rom_dout;

        case (state_q)
            ST_IDLE: begin
                if (scancode_valid) begin
                    if (scancode == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else if (scancode == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (is_ignored(scancode)) begin
                        state_d = ST_IDLE;
                    end else if (scancode == SC_LSHIFT) begin
                        lshift_d = 1'b1;
                    end else if (scancode == SC_RSHIFT) begin
                        rshift_d = 1'b1;
                    end else if (scancode == SC_CAPS) begin
                        // Typematic repeats of caps arrive as makes; only the first toggles.
                        if (!caps_held_q) begin
                            caps_d = ~caps_q;
                        end
                        caps_held_d = 1'b1;
`ifdef CTRL_KEY_EN
                    end else if (scancode == SC_CTRL) begin
                        ctrl_held_d = 1'b1;
`endif
                    end else begin
                        rom_addr_d = {caps_q, lshift_q | rshift_q, scancode};
                        state_d    = ST_LOOKUP;
                    end
                end
            end
            ST_BRK: begin
                if (scancode_valid) begin
                    if (scancode == SC_LSHIFT) lshift_d = 1'b0;
                    if (scancode == SC_RSHIFT) rshift_d = 1'b0;
                    if (scancode == SC_CAPS)   caps_held_d = 1'b0;
`ifdef CTRL_KEY_EN
                    if (scancode == SC_CTRL)   ctrl_held_d = 1'b0;
`endif
                    state_d = ST_IDLE;
                end
            end
            ST_EXT: begin
                if (scancode_valid) begin
                    state_d = (scancode == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
            end
            ST_EXT_BRK: begin
                if (scancode_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (scancode_valid) overrun_d = 1'b1;
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (scancode_valid) overrun_d = 1'b1;
                fifo_push = (rom_dout != 8'h00);
`ifdef CTRL_KEY_EN
                if (ctrl_held_q && rom_dout[7:6] == 2'b01) begin
                    fifo_push_data = {3'b000, rom_dout[4:0]};
                end
`endif
                if (fifo_push && fifo_full && !fifo_pop) overflow_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            rom_addr_q  <= '0;
            overrun_q   <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef CTRL_KEY_EN
            ctrl_held_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            rom_addr_q  <= rom_addr_d;
            overrun_q   <= overrun_d;
            overflow_q  <= overflow_d;
`ifdef CTRL_KEY_EN
            ctrl_held_q <= ctrl_held_d;
`endif
        end
    end

    char_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_char_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (char_out)
    );

    assign rom_addr  = rom_addr_q;
    assign caps_lock = caps_q;
    assign overrun   = overrun_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keymap_sequencer.sv
// tb/tb_keymap_sequencer.sv - scoreboard bench for keymap_sequencer with a 1-cycle keymap ROM model
module tb_keymap_sequencer;

    logic       clk;
    logic       reset_n;
    logic [7:0] scancode;
    logic       scancode_valid;
    logic [9:0] rom_addr;
    logic [7:0] rom_dout;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;
    logic       caps_lock;
    logic       overrun;
    logic       overflow;

    int         n_pass;
    int         n_total;
    logic [7:0] exp_q [$];

    keymap_sequencer #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .scancode       (scancode),
        .scancode_valid (scancode_valid),
        .rom_addr       (rom_addr),
        .rom_dout       (rom_dout),
        .char_out       (char_out),
        .char_valid     (char_valid),
        .char_ready     (char_ready),
        .caps_lock      (caps_lock),
        .overrun        (overrun),
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only keycode 1C is mapped; every other address reads 0x00.
    function automatic logic [7:0] rom_model(input logic [9:0] a);
        if (a[7:0] != 8'h1C) return 8'h00;
        case (a[9:8])
            2'd0:    return 8'h61;
            2'd1:    return 8'h41;
            2'd2:    return 8'h41;
            default: return 8'h61;
        endcase
    endfunction

    always @(posedge clk) rom_dout <= rom_model(rom_addr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scancode       = b;
        scancode_valid = 1'b1;
        @(negedge clk);
        scancode_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [7:0] code, input logic [9:0] exp_addr,
                         input logic [7:0] exp_char, input logic pop_at_capture);
        @(negedge clk);
        scancode       = code;
        scancode_valid = 1'b1;
        @(negedge clk);
        scancode_valid = 1'b0;
        check("rom_addr", rom_addr, exp_addr);
        @(negedge clk);
        if (pop_at_capture) begin
            check("pop_valid", char_valid, 1);
            if (exp_q.size() > 0) check("pop_char", char_out, exp_q.pop_front());
            else check("pop_extra", char_valid, 0);
            char_ready = 1'b1;
        end
        if (exp_char != 8'h00) exp_q.push_back(exp_char);
        @(negedge clk);
        char_ready = 1'b0;
    endtask

    task automatic drain();
        char_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (char_valid) begin
                if (exp_q.size() > 0) check("char", char_out, exp_q.pop_front());
                else check("extra_char", char_valid, 0);
            end else if (exp_q.size() == 0) begin
                break;
            end
            @(negedge clk);
        end
        char_ready = 1'b0;
        check("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        n_pass         = 0;
        n_total        = 0;
        reset_n        = 1'b0;
        scancode       = 8'h00;
        scancode_valid = 1'b0;
        char_ready     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rom_addr", rom_addr, 0);
        check("rst_char_valid", char_valid, 0);
        check("rst_char_out", char_out, 0);
        check("rst_caps", caps_lock, 0);
        check("rst_overrun", overrun, 0);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;

        // Single key: latency and pop.
        @(negedge clk);
        scancode       = 8'h1C;
        scancode_valid = 1'b1;
        @(negedge clk);
        scancode_valid = 1'b0;
        check("lat_addr", rom_addr, 10'h01C);
        check("lat_valid_n1", char_valid, 0);
        @(negedge clk);
        check("lat_valid_n2", char_valid, 0);
        @(negedge clk);
        check("lat_valid_n3", char_valid, 1);
        check("lat_char", char_out, 8'h61);
        char_ready = 1'b1;
        @(negedge clk);
        char_ready = 1'b0;
        check("pop_cleared", char_valid, 0);
        check("pop_char_zero", char_out, 0);

        // Shift make/break.
        send_byte(8'h12);
        press(8'h1C, 10'h11C, 8'h41, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        press(8'h1C, 10'h01C, 8'h61, 1'b0);
        drain();

        // Caps lock and typematic repeat.
        send_byte(8'h58);
        check("caps_on", caps_lock, 1);
        send_byte(8'hF0);
        send_byte(8'h58);
        press(8'h1C, 10'h21C, 8'h41, 1'b0);
        send_byte(8'h58);
        check("caps_off", caps_lock, 0);
        send_byte(8'h58);
        check("caps_repeat", caps_lock, 0);
        send_byte(8'hF0);
        send_byte(8'h58);
        check("caps_release", caps_lock, 0);
        drain();

        // Extended keys and a bare break never reach the ROM.
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("ext_no_char", char_valid, 0);
        check("ext_rom_addr", rom_addr, 10'h21C);
        check("ext_no_overrun", overrun, 0);

        // Back-to-back strobes: second is an overrun.
        @(negedge clk);
        scancode       = 8'h1C;
        scancode_valid = 1'b1;
        @(negedge clk);
        check("ovr_addr", rom_addr, 10'h01C);
        @(negedge clk);
        scancode_valid = 1'b0;
        exp_q.push_back(8'h61);
        repeat (3) @(negedge clk);
        check("overrun_set", overrun, 1);
        drain();

        // Fill FIFO, push-while-pop on full, then drop on full.
        for (int i = 0; i < 4; i++) press(8'h1C, 10'h01C, 8'h61, 1'b0);
        check("full_no_ovf", overflow, 0);
        press(8'h1C, 10'h01C, 8'h61, 1'b1);
        check("popfull_no_ovf", overflow, 0);
        check("popfull_valid", char_valid, 1);
        press(8'h1C, 10'h01C, 8'h00, 1'b0);
        check("overflow_set", overflow, 1);
        drain();

        // Reset mid-lookup.
        @(negedge clk);
        scancode       = 8'h1C;
        scancode_valid = 1'b1;
        @(negedge clk);
        scancode_valid = 1'b0;
        reset_n        = 1'b0;
        #1;
        check("mid_rst_addr", rom_addr, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_overflow", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_no_char", char_valid, 0);
        press(8'h1C, 10'h01C, 8'h61, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keymap_sequencer.md
Name: keymap_sequencer

Overview:
Sits between the PS/2 scancode receiver and the 1 KB keymap ROM (synchronous, 1-cycle read, 10-bit address = {caps, shift, keycode}). Decodes make/break/extended prefixes and tracks shift and caps-lock state. Drives the ROM address, captures the ASCII result and queues it in a small FIFO for the terminal core.

Parameters:
FIFO_DEPTH, 4, character FIFO entries; power of two, minimum 2.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
scancode  in  8  byte from PS/2 receiver
scancode_valid  in  1  one-cycle strobe, scancode valid
rom_addr  out  10  keymap ROM address {caps_lock, shift, keycode}, registered
rom_dout  in  8  keymap ROM data, valid the cycle after rom_addr is presented
char_out  out  8  FIFO head character; 0 when empty
char_valid  out  1  FIFO not empty
char_ready  in  1  consumer pops head when char_valid & char_ready
caps_lock  out  1  caps-lock state (LED)
overrun  out  1  sticky: scancode arrived while busy
overflow  out  1  sticky: character dropped, FIFO full

Behaviour:
- Reset values: rom_addr=0, char_valid=0, char_out=0, caps_lock=0, overrun=0, overflow=0, shift state=0, FSM=IDLE, FIFO empty.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (E0 F0), LOOKUP, CAPTURE.
- IDLE, scancode_valid high:
  - F0 -> BRK.
  - E0 -> EXT.
  - E1, AA, FA, FE, 00, FF -> ignored, stay IDLE.
  - 12 -> lshift=1. 59 -> rshift=1.
  - 58 -> toggle caps_lock only if caps_held=0, then set caps_held=1 (typematic repeat does not re-toggle).
  - Any other code -> rom_addr <= {caps_lock, lshift|rshift, code}, go LOOKUP.
- BRK, next byte: 12 clears lshift, 59 clears rshift, 58 clears caps_held; any other byte is discarded. Return to IDLE.
- EXT, next byte: F0 -> EXT_BRK; any other byte is discarded -> IDLE. EXT_BRK, next byte: discarded -> IDLE. Extended keys never reach the ROM.
- LOOKUP: one wait cycle for the ROM read -> CAPTURE.
- CAPTURE: sample rom_dout. Nonzero -> push to FIFO. 0x00 (unmapped) -> dropped, no flag. Then -> IDLE.
- Latency: scancode strobe in cycle N -> rom_addr valid in N+1 -> rom_dout sampled in N+2 -> char_valid high in N+3 if FIFO was empty. No bypass path.
- scancode_valid during LOOKUP or CAPTURE: byte dropped, overrun <= 1. Prefix state is unaffected.
- Modifier state is sampled when rom_addr is registered. A later modifier change does not alter an in-flight lookup.
- FIFO:
  - Pop and push in the same cycle: the pop is applied first, so a push into a full FIFO that is popping is accepted.
  - Push into a full FIFO with no pop: character dropped, overflow <= 1.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits.
- overrun and overflow are cleared only by reset.
- Asserting reset mid-lookup abandons the lookup and returns all state to reset values immediately.

Optional Feature:
CTRL_KEY_EN.
- Defined: code 14 (left ctrl) make/break tracks ctrl_held like shift. 14 is then never looked up. While ctrl_held, a captured character in 0x40-0x7F is pushed as char & 0x1F (e.g. 'c' 0x63 -> 0x03).
- Undefined: no ctrl tracking; 14 is looked up like any other code.

Decomposition:
- Package keyboard_pkg:
  - Scancode constants SC_BREAK=F0, SC_EXT=E0, SC_PAUSE=E1, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58, SC_CTRL=14.
  - Ignore-list constants.
  - FSM state enum.
  - ROM address field widths.
- One sub-module: char_fifo, a parameterised synchronous FIFO with push/pop/full/empty and head data.

Test Plan:
- Bench ROM model maps plane0 1C->'a'(61), plane1 1C->'A'(41), plane2 1C->'A', plane3 1C->'a'.
- 1C alone -> rom_addr=01C one cycle later; char_out=61 with char_valid high 3 cycles after the strobe; pop clears char_valid.
- 12, 1C, F0 1C, F0 12, 1C -> FIFO yields 41 then 61; rom_addr values 11C then 01C.
- 58, F0 58, 1C -> caps_lock=1, char 41. Then 58, 58 (repeat), F0 58 -> caps_lock=0 after the first 58 only.
- E0 75, E0 F0 75 -> no ROM lookup, FIFO stays empty. F0 1C -> no character.
- Strobe 1C twice on consecutive cycles -> one character (61) and overrun=1.
- FIFO_DEPTH=4, char_ready=0, five 1C presses -> 4 entries, overflow=1. With char_ready=1 held during a full-FIFO push -> push accepted, no overflow.
